// File: rtl/timer_responder_if.sv
// timer_responder_if: CPU-side load/store bus of the interval timer.
//   addr  word select (CPU address bits [3:2])
//   we    store strobe
//   din   store data
//   dout  load data, driven by the timer
//   irq   interrupt request, driven by the timer
// master = CPU side, slave = timer side.
interface timer_responder_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  modport master (output addr, output we, output din, input dout, input irq);
  modport slave  (input addr, input we, input din, output dout, output irq);
endinterface

// File: rtl/timer_responder.sv
// timer_responder: memory-mapped down-counting interval timer.
// Word map: 0=CTRL {IM, Mode[1:0], En}, 1=PRESET, 2=COUNT (read-only), 3=reserved.
// Ports:
//   clk    system clock, all state updates on its rising edge
//   reset  synchronous active-high reset
//   bus    timer_responder_if.slave (addr, we, din in; dout, irq out)
// Loads are zero latency (dout is combinational from addr); irq = int_flag & IM.
module timer_responder (
  input  logic                 clk,
  input  logic                 reset,
  timer_responder_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  ctrl_r, ctrl_s;
  logic [31:0] preset_r, preset_s;
  logic [31:0] count_r, count_s;
  logic        int_flag_r, int_flag_s;
  logic        flag_set_s;
  logic        wr_ctrl_s;
  logic        wr_preset_s;

  assign wr_ctrl_s   = bus.we && (bus.addr == 2'd0);
  assign wr_preset_s = bus.we && (bus.addr == 2'd1);

  // Next-state logic: FSM first, then CPU stores, so a CTRL store overrides the FSM's En clear.
  always_comb begin
    state_s    = state_r;
    ctrl_s     = ctrl_r;
    preset_s   = preset_r;
    count_s    = count_r;
    int_flag_s = int_flag_r;
    flag_set_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (ctrl_r[0]) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        count_s = preset_r;
        state_s = CNT;
      end
      CNT: begin
        if (!ctrl_r[0]) begin
          state_s = IDLE;
        end else if (count_r > 32'd1) begin
          count_s = count_r - 32'd1;
        end else begin
          // count of 0 or 1 both terminate, so preset=0 acts like preset=1
          count_s    = 32'd0;
          int_flag_s = 1'b1;
          flag_set_s = 1'b1;
          state_s    = INT;
        end
      end
      INT: begin
        if (ctrl_r[2:1] == 2'd1) begin
          int_flag_s = 1'b0;
          state_s    = LOAD;
        end else begin
          ctrl_s[0] = 1'b0;
          state_s   = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (wr_ctrl_s) begin
      ctrl_s = bus.din[3:0];
      // a fresh terminal count in this same cycle must not be lost
      if (bus.din[0] && !flag_set_s) begin
        int_flag_s = 1'b0;
      end else begin
        int_flag_s = int_flag_s;
      end
    end else begin
      ctrl_s = ctrl_s;
    end

    if (wr_preset_s) begin
      preset_s = bus.din;
    end else begin
      preset_s = preset_r;
    end
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      ctrl_r     <= 4'd0;
      preset_r   <= 32'd0;
      count_r    <= 32'd0;
      int_flag_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      ctrl_r     <= ctrl_s;
      preset_r   <= preset_s;
      count_r    <= count_s;
      int_flag_r <= int_flag_s;
    end
  end

  // Zero-latency load data mux.
  always_comb begin
    case (bus.addr)
      2'd0:    bus.dout = {28'd0, ctrl_r};
      2'd1:    bus.dout = preset_r;
      2'd2:    bus.dout = count_r;
      default: bus.dout = 32'd0;
    endcase
  end

  assign bus.irq = int_flag_r & ctrl_r[3];

endmodule
